// File: rtl/perf_stats_uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : perf_stats_uart_tx_if
// Description : Counter inputs, start request and UART/status outputs of the
//               performance-statistics UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
interface perf_stats_uart_tx_if;
    logic        start;
    logic [27:0] clk_cycles;
    logic [12:0] retired_instructions;
    logic [12:0] predictions_made;
    logic [12:0] correct_predictions;
    logic [12:0] invalid_clk_cycles;
    logic        tx;
    logic        busy;
    logic        frame_done;

    modport master (
        output start, clk_cycles, retired_instructions, predictions_made,
               correct_predictions, invalid_clk_cycles,
        input  tx, busy, frame_done
    );

    modport slave (
        input  start, clk_cycles, retired_instructions, predictions_made,
               correct_predictions, invalid_clk_cycles,
        output tx, busy, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/perf_stats_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : perf_stats_uart_tx
// Description : Snapshots five performance counters and sends them as a
//               14-byte framed packet on an 8N1 UART line.
// Revision    : 1.0 - initial release
// ============================================================================
module perf_stats_uart_tx #(
    parameter int         CLKS_PER_BIT = 651,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
    input wire clk,
    input wire rst,
    perf_stats_uart_tx_if.slave bus
);
    localparam int               c_BW       = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_BW-1:0]  c_BAUD_MAX = c_BW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       c_LAST_BYTE = 4'd13;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_START = 2'd1;
    localparam logic [1:0] c_ST_DATA  = 2'd2;
    localparam logic [1:0] c_ST_STOP  = 2'd3;

    logic [1:0]      r_state;
    logic [c_BW-1:0] r_baud;
    logic [2:0]      r_bit_idx;
    logic [3:0]      r_byte_idx;
    logic [7:0]      r_shift;
    logic [7:0]      r_frame [14];
    logic            r_tx;
    logic            r_busy;
    logic            r_frame_done;

    logic [7:0]      w_frame [14];
    logic [31:0]     w_clk32;
    logic [15:0]     w_f16 [4];
    logic [7:0]      w_csum;
    logic            w_bit_end;

    // Whole frame (sync, payload, checksum) is built from the live counters
    // and latched in one go, so the transmitted packet is a coherent snapshot.
    always_comb begin
        w_clk32  = {4'd0, bus.clk_cycles};
        w_f16[0] = {3'd0, bus.retired_instructions};
        w_f16[1] = {3'd0, bus.predictions_made};
        w_f16[2] = {3'd0, bus.correct_predictions};
        w_f16[3] = {3'd0, bus.invalid_clk_cycles};
        w_frame[0] = SYNC_BYTE;
        for (int i = 0; i < 4; i++) begin
            w_frame[1 + i]     = w_clk32[8*i +: 8];
            w_frame[5 + 2*i]   = w_f16[i][7:0];
            w_frame[6 + 2*i]   = w_f16[i][15:8];
        end
        w_csum = 8'd0;
        for (int i = 1; i < 13; i++) begin
            w_csum = w_csum ^ w_frame[i];
        end
        w_frame[13] = w_csum;
    end

    assign w_bit_end = (r_baud == c_BAUD_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_baud       <= '0;
            r_bit_idx    <= '0;
            r_byte_idx   <= '0;
            r_shift      <= '0;
            r_tx         <= 1'b1;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            for (int i = 0; i < 14; i++) begin
                r_frame[i] <= '0;
            end
        end else begin
            r_frame_done <= 1'b0;
            r_baud       <= w_bit_end ? '0 : r_baud + 1'b1;
            case (r_state)
                c_ST_IDLE: begin
                    r_baud <= '0;
                    if (bus.start) begin
                        for (int i = 0; i < 14; i++) begin
                            r_frame[i] <= w_frame[i];
                        end
                        r_state    <= c_ST_START;
                        r_byte_idx <= '0;
                        r_tx       <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                c_ST_START: begin
                    if (w_bit_end) begin
                        r_state   <= c_ST_DATA;
                        r_bit_idx <= '0;
                        r_tx      <= r_frame[r_byte_idx][0];
                        r_shift   <= r_frame[r_byte_idx] >> 1;
                    end
                end
                c_ST_DATA: begin
                    if (w_bit_end) begin
                        if (r_bit_idx == 3'd7) begin
                            r_state <= c_ST_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_tx      <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                        end
                    end
                end
                default: begin
                    // Stop bit flows straight into the next start bit: no idle gap.
                    if (w_bit_end) begin
                        if (r_byte_idx == c_LAST_BYTE) begin
                            r_state      <= c_ST_IDLE;
                            r_busy       <= 1'b0;
                            r_frame_done <= 1'b1;
                            r_tx         <= 1'b1;
                        end else begin
                            r_state    <= c_ST_START;
                            r_byte_idx <= r_byte_idx + 4'd1;
                            r_tx       <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.tx         = r_tx;
    assign bus.busy       = r_busy;
    assign bus.frame_done = r_frame_done;
endmodule
`default_nettype wire
